// File: rtl/fifo_wr_sched_pkg.sv
// Shared types and width helpers for the FIFO write scheduler and its
// round-robin picker.
package fifo_wr_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Index width for an n-entry selection, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Credit counter must hold every value 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_sched_rr_pick.sv
// Combinational rotate-priority picker: first set request after the
// last-granted index, wrapping around.
module rr_pick
  import fifo_wr_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int cand;
    cand  = 0;
    found = 1'b0;
    idx   = last;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(last) + off) % N;
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// Round-robin write scheduler: grants one producer at a time into a shared
// FIFO, bounded by burst length and a local free-space credit count.
module fifo_wr_sched
  import fifo_wr_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 512,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ*WIDTH-1:0]           req_data,
  input  logic [N_REQ-1:0]                 req_last,
  output logic [N_REQ-1:0]                 req_ready,
  output logic                             fifo_write,
  output logic [WIDTH-1:0]                 fifo_data,
  input  logic                             fifo_read,
  output logic [idx_width(N_REQ)-1:0]      grant_id,
  output logic                             busy,
  output logic [credit_width(DEPTH)-1:0]   credits,
  output logic                             err_credit
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = credit_width(DEPTH);
  localparam int BW = idx_width(MAX_BURST);
  localparam logic [CW-1:0] FULL_CREDITS = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT    = BW'(MAX_BURST - 1);

  state_e          state, state_nxt;
  logic [BW-1:0]   beat_cnt;
  logic [CW-1:0]   credits_nxt;
  logic [WIDTH-1:0] req_word [N_REQ];
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            has_credit, grant_valid, grant_last, accept;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign req_word[i] = req_data[i*WIDTH +: WIDTH];
  end

  assign has_credit  = (credits != '0);
  assign grant_valid = req_valid[grant_id];
  assign grant_last  = req_last[grant_id];
  assign accept      = (state == BURST) && grant_valid && has_credit;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .last  (grant_id),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: defaulting state_nxt first keeps every path assigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_found && has_credit) state_nxt = BURST;
      BURST: begin
        if (!grant_valid) state_nxt = IDLE;
        else if (accept && (grant_last || beat_cnt == LAST_BEAT)) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state == BURST);
    if (state == BURST) req_ready[grant_id] = has_credit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id <= IW'(N_REQ - 1);
      beat_cnt <= '0;
    end else if (state == IDLE && state_nxt == BURST) begin
      grant_id <= pick_idx;
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // NOTE: the wide data register is reset because its idle value is observable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_write <= 1'b0;
      fifo_data  <= '0;
    end else begin
      fifo_write <= accept;
      if (accept) fifo_data <= req_word[grant_id];
    end
  end

  // A read at full credit with nothing written means the consumer popped
  // a word this block never pushed.
  always_comb begin
    credits_nxt = credits;
    if (accept && !fifo_read)
      credits_nxt = credits - 1'b1;
    else if (!accept && fifo_read && credits != FULL_CREDITS)
      credits_nxt = credits + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits    <= FULL_CREDITS;
      err_credit <= 1'b0;
    end else begin
      credits <= credits_nxt;
      if (fifo_read && !accept && credits == FULL_CREDITS) err_credit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed scoreboard bench for fifo_wr_sched: per-lane producer queues,
// expected FIFO words queued at issue, checked by a negedge monitor.
module tb_fifo_wr_sched;

  localparam int NR = 4;
  localparam int W  = 512;
  localparam int DP = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              fifo_write;
  logic [W-1:0]      fifo_data;
  logic              fifo_read;
  logic [1:0]        grant_id;
  logic              busy;
  logic [3:0]        credits;
  logic              err_credit;

  fifo_wr_sched #(.N_REQ(NR), .WIDTH(W), .DEPTH(DP), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_write (fifo_write),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .grant_id   (grant_id),
    .busy       (busy),
    .credits    (credits),
    .err_credit (err_credit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic         bubble;
  } beat_t;

  beat_t       lane_q [NR][$];
  logic [W-1:0] exp_q[$];
  int          glog_id[$];
  int          glog_cyc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc = 0;
  int          wr_cnt, rdy_cnt, min_cr, max_cr;
  int          first_valid_cyc, first_rdy_cyc, first_wr_cyc;
  logic        busy_prev = 1'b0;
  logic [NR-1:0] bubble_on;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int lane, input int n);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(lane << 8) | 32'(n);
    return {16{w}};
  endfunction

  task automatic push_beat(input int lane, input int n, input logic last);
    beat_t b;
    b.data = mk(lane, n);
    b.last = last;
    b.bubble = 1'b0;
    lane_q[lane].push_back(b);
    exp_q.push_back(b.data);
  endtask

  task automatic push_bubble(input int lane);
    beat_t b;
    b.data = '0;
    b.last = 1'b0;
    b.bubble = 1'b1;
    lane_q[lane].push_back(b);
  endtask

  function automatic bit lanes_empty();
    for (int i = 0; i < NR; i++) if (lane_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_stats();
    wr_cnt = 0; rdy_cnt = 0; min_cr = 99; max_cr = -1;
    first_valid_cyc = -1; first_rdy_cyc = -1; first_wr_cyc = -1;
    glog_id.delete();
    glog_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    fifo_read = 1'b0;
    for (int i = 0; i < NR; i++) lane_q[i].delete();
    #1 clear_stats();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (req_valid == '0) && !busy && !fifo_write && lanes_empty();
    end
    check(name, done, 1'b1);
  endtask

  // Producer model: presents each lane's queue head, pops on handshake.
  initial begin
    logic [NR-1:0] acc;
    req_valid = '0; req_data = '0; req_last = '0; bubble_on = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) acc[i] = bubble_on[i] | (req_valid[i] & req_ready[i]);
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
        req_valid[i] = 1'b0; req_last[i] = 1'b0; bubble_on[i] = 1'b0;
        if (lane_q[i].size() != 0) begin
          if (lane_q[i][0].bubble) bubble_on[i] = 1'b1;
          else begin
            req_valid[i] = 1'b1;
            req_last[i]  = lane_q[i][0].last;
            req_data[i*W +: W] = lane_q[i][0].data;
          end
        end
      end
    end
  end

  // Monitor: scoreboard on every FIFO write plus activity statistics.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (fifo_write) begin
          wr_cnt++;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          check("sb_expected_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_fifo_data", fifo_data, e);
          end
        end
        if (req_ready != '0) begin
          rdy_cnt++;
          if (first_rdy_cyc < 0) first_rdy_cyc = cyc;
        end
        if (req_valid != '0 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (busy && !busy_prev) begin
          glog_id.push_back(int'(grant_id));
          glog_cyc.push_back(cyc);
        end
        if (int'(credits) < min_cr) min_cr = int'(credits);
        if (int'(credits) > max_cr) max_cr = int'(credits);
      end
      busy_prev = busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    reset = 1'b1;
    fifo_read = 1'b0;
    clear_stats();

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_write", fifo_write, 1'b0);
    check("rst_fifo_data", fifo_data, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_credits", credits, 8);
    check("rst_grant_id", grant_id, 3);
    check("rst_err_credit", err_credit, 1'b0);

    // Single 3-beat packet from requester 0
    push_beat(0, 0, 1'b0);
    push_beat(0, 1, 1'b0);
    push_beat(0, 2, 1'b1);
    wait_done("t1_drain", 50);
    check("t1_writes", wr_cnt, 3);
    check("t1_ready_cycles", rdy_cnt, 3);
    check("t1_arb_latency", first_rdy_cyc - first_valid_cyc, 1);
    check("t1_write_lag", first_wr_cyc - first_rdy_cyc, 1);
    check("t1_credits", credits, 5);
    check("t1_grant_id", grant_id, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // All four requesters streaming, consumer reading every cycle
    do_reset();
    fifo_read = 1'b1;
    for (int g = 0; g < 2; g++)
      for (int l = 0; l < NR; l++)
        for (int b = 0; b < MB; b++) push_beat(l, g*MB + b, 1'b0);
    wait_done("t2_drain", 200);
    fifo_read = 1'b0;
    check("t2_grant_count", glog_id.size(), 8);
    for (int k = 0; k < 8 && k < glog_id.size(); k++)
      check("t2_grant_order", glog_id[k], k % NR);
    for (int k = 0; k + 1 < glog_cyc.size(); k++)
      check("t2_grant_spacing", glog_cyc[k+1] - glog_cyc[k], MB + 1);
    check("t2_credit_min_ge7", min_cr >= 7, 1'b1);
    check("t2_credit_max_le8", max_cr <= 8, 1'b1);
    check("t2_sb_empty", exp_q.size(), 0);

    // Credit exhaustion mid-burst, then a single credit return
    do_reset();
    push_beat(0, 0, 1'b0);
    push_beat(0, 1, 1'b1);
    for (int b = 0; b < 10; b++) push_beat(2, b, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = (credits == 0) && busy;
    end
    check("t3_reach_stall", hit, 1'b1);
    repeat (2) @(negedge clk);
    check("t3_stall_credits", credits, 0);
    check("t3_stall_busy", busy, 1'b1);
    check("t3_stall_ready", req_ready, '0);
    check("t3_stall_writes", wr_cnt, 8);
    check("t3_stall_fifo_write", fifo_write, 1'b0);
    check("t3_stall_grant", grant_id, 2);
    fifo_read = 1'b1;
    @(negedge clk);
    fifo_read = 1'b0;
    check("t3_return_credits", credits, 1);
    check("t3_return_ready", req_ready, 4'b0100);
    @(negedge clk);
    check("t3_ninth_write", fifo_write, 1'b1);
    check("t3_ninth_credits", credits, 0);
    check("t3_ninth_busy", busy, 1'b1);
    fifo_read = 1'b1;
    wait_done("t3_drain", 100);
    fifo_read = 1'b0;
    check("t3_sb_empty", exp_q.size(), 0);

    // Simultaneous accept/read, then over-return of credits
    do_reset();
    for (int b = 0; b < 8; b++) push_beat(3, b, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = (credits == 3) && busy && req_ready[3];
    end
    check("t4_reach_c3", hit, 1'b1);
    fifo_read = 1'b1;
    @(negedge clk);
    fifo_read = 1'b0;
    check("t4_same_cycle_credits", credits, 3);
    check("t4_same_cycle_write", fifo_write, 1'b1);
    wait_done("t4_drain", 50);
    check("t4_after_drain_credits", credits, 1);
    fifo_read = 1'b1;
    repeat (7) @(negedge clk);
    fifo_read = 1'b0;
    check("t4_full_credits", credits, 8);
    check("t4_err_not_yet", err_credit, 1'b0);
    fifo_read = 1'b1;
    @(negedge clk);
    fifo_read = 1'b0;
    check("t4_saturate", credits, 8);
    check("t4_err_set", err_credit, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", err_credit, 1'b1);
    check("t4_sb_empty", exp_q.size(), 0);
    do_reset();
    @(negedge clk);
    check("t4_err_cleared", err_credit, 1'b0);

    // Bubble ends a grant; the waiting requester goes next
    push_beat(1, 0, 1'b0);
    push_beat(1, 1, 1'b0);
    push_bubble(1);
    push_beat(3, 0, 1'b0);
    push_beat(3, 1, 1'b1);
    push_beat(1, 2, 1'b0);
    push_beat(1, 3, 1'b1);
    wait_done("t5_drain", 60);
    check("t5_grant_count", glog_id.size(), 3);
    if (glog_id.size() == 3) begin
      check("t5_grant0", glog_id[0], 1);
      check("t5_grant1", glog_id[1], 3);
      check("t5_grant2", glog_id[2], 1);
      check("t5_bubble_grant_len", glog_cyc[1] - glog_cyc[0], 4);
    end
    check("t5_sb_empty", exp_q.size(), 0);

    // Reset asserted mid-burst after the second beat
    do_reset();
    for (int b = 0; b < 4; b++) begin
      beat_t bt;
      bt.data = mk(0, b); bt.last = 1'b0; bt.bubble = 1'b0;
      lane_q[0].push_back(bt);
    end
    exp_q.push_back(mk(0, 0));
    exp_q.push_back(mk(0, 1));
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      hit = (credits == 6) && busy;
    end
    check("t6_reach_beat2", hit, 1'b1);
    #2;
    reset = 1'b1;
    for (int i = 0; i < NR; i++) lane_q[i].delete();
    #1;
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_fifo_write", fifo_write, 1'b0);
    check("t6_async_ready", req_ready, '0);
    check("t6_async_credits", credits, 8);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_post_credits", credits, 8);
    check("t6_post_grant_id", grant_id, 3);
    check("t6_post_busy", busy, 1'b0);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
